conv_tap_mask_seq: RTL and testbench



---
 rtl/conv_tap_mask_seq_pkg.sv | 30 +++
 rtl/conv_tap_mask_seq_tap_mask_pack.sv | 29 ++
 rtl/conv_tap_mask_seq.sv | 189 ++++++++++++++++++
 tb/tb_conv_tap_mask_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_tap_mask_seq_pkg.sv
// Shared parameters, FSM encoding and window-count helper for the tap-mask sequencer.
// Other files pull these in with a package import.
package conv_tap_mask_seq_pkg;

    localparam int K_MAX  = 8;
    localparam int F_W    = $clog2(K_MAX);
    localparam int DIM_W  = 10;
    localparam int STR_W  = 2;
    localparam int K_W    = F_W + 1;
    localparam int CNT_W  = DIM_W + 2;
    localparam int MASK_W = K_MAX * K_MAX;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Output positions along one axis; only meaningful for a legal config.
    function automatic logic [CNT_W-1:0] win_count(
        input logic [DIM_W-1:0] dim,
        input logic [F_W-1:0]   pad,
        input logic [K_W-1:0]   k,
        input logic [STR_W:0]   s
    );
        logic [CNT_W-1:0] span;
        span = CNT_W'(dim) + (CNT_W'(pad) << 1) - CNT_W'(k);
        return span / CNT_W'(s) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/conv_tap_mask_seq_tap_mask_pack.sv
// Packs per-row/per-column tap validity into a k*k enable mask, tap (r,c) at bit r*k+c.
// Purely combinational; bits at index >= k*k are always 0.
module tap_mask_pack
    import conv_tap_mask_seq_pkg::*;
(
    input  logic [K_W-1:0]    i_k,
    input  logic [K_MAX-1:0]  i_row_ok,
    input  logic [K_MAX-1:0]  i_col_ok,
    output logic [MASK_W-1:0] o_mask
);

    localparam int IDX_W = $clog2(MASK_W);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_mask = '0;
        w_idx  = '0;
        for (int r = 0; r < K_MAX; r++) begin
            for (int c = 0; c < K_MAX; c++) begin
                if ((r < int'(i_k)) && (c < int'(i_k))) begin
                    w_idx         = IDX_W'(r) * IDX_W'(i_k) + IDX_W'(c);
                    o_mask[w_idx] = i_row_ok[r] & i_col_ok[c];
                end
            end
        end
    end

endmodule

// File: rtl/conv_tap_mask_seq.sv
// Walks the output windows of one conv layer and emits the padding-aware multiplier-enable mask.
// First window 1 cycle after an accepted Start; outputs hold while Win_ready is low, 1 window/cycle otherwise.
module conv_tap_mask_seq
    import conv_tap_mask_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               Local_Reset,
    input  logic               Start,
    input  logic [F_W-1:0]     F,
    input  logic [F_W-1:0]     Pad,
    input  logic [STR_W-1:0]   Stride,
    input  logic [DIM_W-1:0]   Img_W,
    input  logic [DIM_W-1:0]   Img_H,
    input  logic               Win_ready,
    output logic               Win_valid,
    output logic [MASK_W-1:0]  Mul_en,
    output logic [DIM_W-1:0]   Win_row,
    output logic [DIM_W-1:0]   Win_col,
    output logic               Last_win,
    output logic               Busy,
    output logic               Cfg_err
);

    state_t                   r_state, w_state_nxt;
    logic [K_W-1:0]           r_k, w_k_nxt, w_k_in;
    logic [F_W-1:0]           r_pad, w_pad_nxt;
    logic [STR_W:0]           r_s, w_s_nxt, w_s_in;
    logic [DIM_W-1:0]         r_img_w, r_img_h, w_img_w_nxt, w_img_h_nxt;
    logic [CNT_W-1:0]         r_ncols, r_nrows, w_ncols_nxt, w_nrows_nxt;
    logic [CNT_W-1:0]         r_col, r_row, w_col_nxt, w_row_nxt;
    logic signed [CNT_W-1:0]  r_x0, r_y0, w_x0_nxt, w_y0_nxt;
    logic                     r_vld, r_busy, r_last, r_cfg_err;
    logic                     w_vld_nxt, w_busy_nxt, w_last_nxt, w_cfg_err_nxt;
    logic [MASK_W-1:0]        r_mul_en, w_mask;
    logic                     w_cfg_ok;
    logic [K_MAX-1:0]         w_row_ok, w_col_ok;
    logic signed [CNT_W-1:0]  w_tx, w_ty;

    assign w_k_in = K_W'(F) + K_W'(1);
    assign w_s_in = (STR_W+1)'(Stride) + (STR_W+1)'(1);

    assign w_cfg_ok = (K_W'(Pad) < w_k_in)
                   && (CNT_W'(w_k_in) <= CNT_W'(Img_W) + (CNT_W'(Pad) << 1))
                   && (CNT_W'(w_k_in) <= CNT_W'(Img_H) + (CNT_W'(Pad) << 1))
                   && (Img_W != '0) && (Img_H != '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_pad_nxt     = r_pad;
        w_s_nxt       = r_s;
        w_img_w_nxt   = r_img_w;
        w_img_h_nxt   = r_img_h;
        w_ncols_nxt   = r_ncols;
        w_nrows_nxt   = r_nrows;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_x0_nxt      = r_x0;
        w_y0_nxt      = r_y0;
        w_vld_nxt     = r_vld;
        w_busy_nxt    = r_busy;
        w_cfg_err_nxt = 1'b0;
        if (Local_Reset) begin
            w_state_nxt = S_IDLE;
            w_vld_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (w_cfg_ok) begin
                            w_state_nxt = S_RUN;
                            w_k_nxt     = w_k_in;
                            w_pad_nxt   = Pad;
                            w_s_nxt     = w_s_in;
                            w_img_w_nxt = Img_W;
                            w_img_h_nxt = Img_H;
                            w_ncols_nxt = win_count(Img_W, Pad, w_k_in, w_s_in);
                            w_nrows_nxt = win_count(Img_H, Pad, w_k_in, w_s_in);
                            w_col_nxt   = '0;
                            w_row_nxt   = '0;
                            w_x0_nxt    = -$signed(CNT_W'(Pad));
                            w_y0_nxt    = -$signed(CNT_W'(Pad));
                            w_vld_nxt   = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_vld && Win_ready) begin
                        if (r_last) begin
                            w_state_nxt = S_IDLE;
                            w_vld_nxt   = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_col_nxt   = '0;
                            w_row_nxt   = '0;
                        end else if (r_col == r_ncols - CNT_W'(1)) begin
                            w_col_nxt = '0;
                            w_x0_nxt  = -$signed(CNT_W'(r_pad));
                            w_row_nxt = r_row + CNT_W'(1);
                            w_y0_nxt  = r_y0 + $signed(CNT_W'(r_s));
                        end else begin
                            w_col_nxt = r_col + CNT_W'(1);
                            w_x0_nxt  = r_x0 + $signed(CNT_W'(r_s));
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_last_nxt = w_vld_nxt && (w_row_nxt == w_nrows_nxt - CNT_W'(1))
                               && (w_col_nxt == w_ncols_nxt - CNT_W'(1));
    end

    // Mask is built from the window about to be registered, so a stalled window recomputes identically.
    always_comb begin
        w_row_ok = '0;
        w_col_ok = '0;
        w_tx     = '0;
        w_ty     = '0;
        for (int i = 0; i < K_MAX; i++) begin
            w_ty        = w_y0_nxt + $signed(CNT_W'(i));
            w_tx        = w_x0_nxt + $signed(CNT_W'(i));
            w_row_ok[i] = !w_ty[CNT_W-1] && ($unsigned(w_ty) < CNT_W'(w_img_h_nxt));
            w_col_ok[i] = !w_tx[CNT_W-1] && ($unsigned(w_tx) < CNT_W'(w_img_w_nxt));
        end
    end

    tap_mask_pack u_pack (
        .i_k      (w_k_nxt),
        .i_row_ok (w_row_ok),
        .i_col_ok (w_col_ok),
        .o_mask   (w_mask)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_pad     <= '0;
            r_s       <= '0;
            r_img_w   <= '0;
            r_img_h   <= '0;
            r_ncols   <= '0;
            r_nrows   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            r_last    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_mul_en  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_pad     <= w_pad_nxt;
            r_s       <= w_s_nxt;
            r_img_w   <= w_img_w_nxt;
            r_img_h   <= w_img_h_nxt;
            r_ncols   <= w_ncols_nxt;
            r_nrows   <= w_nrows_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_x0      <= w_x0_nxt;
            r_y0      <= w_y0_nxt;
            r_vld     <= w_vld_nxt;
            r_busy    <= w_busy_nxt;
            r_last    <= w_last_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_mul_en  <= w_vld_nxt ? w_mask : '0;
        end
    end

    assign Win_valid = r_vld;
    assign Mul_en    = r_mul_en;
    assign Win_row   = r_row[DIM_W-1:0];
    assign Win_col   = r_col[DIM_W-1:0];
    assign Last_win  = r_last;
    assign Busy      = r_busy;
    assign Cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_conv_tap_mask_seq.sv
// Scoreboard bench for conv_tap_mask_seq: windows predicted from the layer geometry are queued
// at Start and a negedge monitor pops/compares them on every handshake.
module tb_conv_tap_mask_seq;

    logic        CLK;
    logic        RST_n;
    logic        Local_Reset;
    logic        Start;
    logic [2:0]  F;
    logic [2:0]  Pad;
    logic [1:0]  Stride;
    logic [9:0]  Img_W;
    logic [9:0]  Img_H;
    logic        Win_ready;
    logic        Win_valid;
    logic [63:0] Mul_en;
    logic [9:0]  Win_row;
    logic [9:0]  Win_col;
    logic        Last_win;
    logic        Busy;
    logic        Cfg_err;

    conv_tap_mask_seq dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Local_Reset (Local_Reset),
        .Start       (Start),
        .F           (F),
        .Pad         (Pad),
        .Stride      (Stride),
        .Img_W       (Img_W),
        .Img_H       (Img_H),
        .Win_ready   (Win_ready),
        .Win_valid   (Win_valid),
        .Mul_en      (Mul_en),
        .Win_row     (Win_row),
        .Win_col     (Win_col),
        .Last_win    (Last_win),
        .Busy        (Busy),
        .Cfg_err     (Cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] mask;
        int          row;
        int          col;
        bit          last;
    } win_t;

    win_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_block = 1'b0;
    int   hold_req_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit cfg_legal(input int k, input int pad, input int w, input int h);
        return !(pad >= k || k > w + 2*pad || k > h + 2*pad || w == 0 || h == 0);
    endfunction

    // Enumerate window origins directly from the geometry and mark taps inside the image.
    task automatic model_push(input int k, input int pad, input int s, input int w, input int h);
        win_t e;
        int oy, ox, y0, x0;
        oy = 0;
        y0 = -pad;
        while (y0 + k <= h + pad) begin
            ox = 0;
            x0 = -pad;
            while (x0 + k <= w + pad) begin
                e.mask = '0;
                for (int r = 0; r < k; r++)
                    for (int c = 0; c < k; c++)
                        if (y0 + r >= 0 && y0 + r < h && x0 + c >= 0 && x0 + c < w)
                            e.mask[r*k + c] = 1'b1;
                e.row  = oy;
                e.col  = ox;
                e.last = (y0 + s + k > h + pad) && (x0 + s + k > w + pad);
                exp_q.push_back(e);
                ox++;
                x0 += s;
            end
            oy++;
            y0 += s;
        end
    endtask

    initial begin
        int served, left;
        served = 0;
        left = 0;
        Win_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (hold_req_cnt != served) begin
                served = hold_req_cnt;
                left   = 3;
            end
            if (rdy_block) Win_ready = 1'b0;
            else if (left > 0) begin
                Win_ready = 1'b0;
                left--;
            end else Win_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    logic [63:0] prev_mask;
    logic [9:0]  prev_row, prev_col;
    logic        prev_last;
    bit          prev_hold = 1'b0;
    bit          chk_idle = 1'b0;

    always @(negedge CLK) begin
        win_t e;
        if (RST_n) begin
            if (prev_hold) begin
                chk("hold_valid", Win_valid, 1);
                chk("hold_mask", Mul_en, prev_mask);
                chk("hold_row", Win_row, prev_row);
                chk("hold_col", Win_col, prev_col);
                chk("hold_last", Last_win, prev_last);
            end
            if (chk_idle) begin
                chk("idle_busy", Busy, 0);
                chk("idle_valid", Win_valid, 0);
                chk("idle_mask", Mul_en, 0);
                chk_idle = 1'b0;
            end
            if (Win_valid && Win_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_window: got row %0d col %0d, required no window", Win_row, Win_col);
                end else begin
                    e = exp_q.pop_front();
                    chk("win_mask", Mul_en, e.mask);
                    chk("win_row", Win_row, e.row);
                    chk("win_col", Win_col, e.col);
                    chk("win_last", Last_win, e.last);
                    chk("win_busy", Busy, 1);
                    n_pop++;
                    if (e.last) chk_idle = 1'b1;
                end
            end
            prev_hold = Win_valid && !Win_ready && !Local_Reset;
            prev_mask = Mul_en;
            prev_row  = Win_row;
            prev_col  = Win_col;
            prev_last = Last_win;
        end
    end

    task automatic run_cfg(input int f, input int pad, input int str, input int w, input int h,
                           input int hold_at, input int lr_at,
                           input bit chk_first, input logic [63:0] first_mask);
        int k, s, base;
        bit ok, held;
        k = f + 1;
        s = str + 1;
        held = 1'b0;
        ok = cfg_legal(k, pad, w, h);
        if (ok) model_push(k, pad, s, w, h);
        base = n_pop;
        @(posedge CLK);
        #1;
        F = 3'(f);
        Pad = 3'(pad);
        Stride = 2'(str);
        Img_W = 10'(w);
        Img_H = 10'(h);
        Start = 1'b1;
        @(posedge CLK);
        #1;
        if (ok) begin
            // Start stays high into RUN with an illegal config: must be ignored and not relatched.
            F = 3'd0;
            Pad = 3'($urandom_range(7, 1));
            Stride = 2'($urandom_range(3));
            Img_W = 10'($urandom_range(1023));
            Img_H = 10'($urandom_range(1023));
        end else Start = 1'b0;
        @(negedge CLK);
        chk("launch_valid", Win_valid, ok);
        chk("launch_busy", Busy, ok);
        chk("launch_cfg_err", Cfg_err, !ok);
        if (chk_first) chk("first_mask", Mul_en, first_mask);
        @(posedge CLK);
        #1 Start = 1'b0;
        @(negedge CLK);
        chk("cfg_err_one_cycle", Cfg_err, 0);
        if (!ok) begin
            chk("reject_valid", Win_valid, 0);
            chk("reject_busy", Busy, 0);
        end
        for (int i = 0; i < 20000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge CLK);
            if (hold_at >= 0 && !held && n_pop - base == hold_at) begin
                hold_req_cnt++;
                held = 1'b1;
            end
            if (lr_at >= 0 && n_pop - base == lr_at) begin
                rdy_block = 1'b1;
                #1;
                Local_Reset = 1'b1;
                Start = 1'b1;
                F = 3'd2; Pad = 3'd1; Stride = 2'd0; Img_W = 10'd4; Img_H = 10'd4;
                @(posedge CLK);
                #1;
                Local_Reset = 1'b0;
                Start = 1'b0;
                @(negedge CLK);
                chk("lr_valid", Win_valid, 0);
                chk("lr_mask", Mul_en, 0);
                chk("lr_busy", Busy, 0);
                chk("lr_row", Win_row, 0);
                chk("lr_last", Last_win, 0);
                @(negedge CLK);
                chk("lr_start_ignored", Win_valid, 0);
                chk("lr_no_cfg_err", Cfg_err, 0);
                exp_q.delete();
                rdy_block = 1'b0;
                break;
            end
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        exp_q.delete();
        repeat (3) @(posedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n = 1'b0;
        Local_Reset = 1'b0;
        Start = 1'b0;
        F = '0; Pad = '0; Stride = '0; Img_W = '0; Img_H = '0;
        repeat (3) @(negedge CLK);
        chk("rst_valid", Win_valid, 0);
        chk("rst_mask", Mul_en, 0);
        chk("rst_row", Win_row, 0);
        chk("rst_col", Win_col, 0);
        chk("rst_last", Last_win, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_cfg_err", Cfg_err, 0);
        @(posedge CLK);
        #1 RST_n = 1'b1;
        repeat (2) @(posedge CLK);

        rdy_rand = 1'b0;
        run_cfg(2, 1, 0, 4, 4, -1, -1, 1'b1, 64'h1B0);
        run_cfg(7, 0, 0, 8, 8, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_cfg(2, 0, 1, 5, 5, -1, -1, 1'b1, 64'h1FF);
        run_cfg(2, 1, 0, 4, 4, 6, -1, 1'b0, '0);
        run_cfg(2, 1, 0, 4, 4, -1, 5, 1'b0, '0);
        run_cfg(2, 1, 0, 4, 4, -1, -1, 1'b1, 64'h1B0);
        run_cfg(4, 0, 0, 4, 4, -1, -1, 1'b0, '0);
        run_cfg(2, 3, 0, 4, 4, -1, -1, 1'b0, '0);
        run_cfg(0, 0, 0, 0, 4, -1, -1, 1'b0, '0);
        run_cfg(2, 2, 2, 40, 3, -1, -1, 1'b0, '0);

        for (int n = 0; n < 24; n++) begin
            int k, p, w, h, s;
            rdy_rand = (n % 2) == 1;
            k = $urandom_range(8, 1);
            p = ($urandom_range(9) == 0) ? $urandom_range(7) : $urandom_range(k - 1);
            w = ($urandom_range(15) == 0) ? 0 : $urandom_range(12, 1);
            h = $urandom_range(12, 1);
            s = $urandom_range(3);
            run_cfg(k - 1, p, s, w, h, (n % 4 == 2) ? 3 : -1, -1, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
